counter_updown_param: RTL and testbench
=======================================

COUNTER_UPDOWN_PARAM -- requirements
Module: counter_updown_param

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, which is the counter width in bits (legal range 2..32).
REQ-002 The block SHALL take parameter MAX_VALUE, default 2**WIDTH-1, which is the terminal count; the legal range is 1..2**WIDTH-1.
REQ-003 The block SHALL take parameter SATURATE, default 0, which selects the boundary mode: 0 = wrap, 1 = hold at boundary.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous clear of count to 0.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-008 The block SHALL have port load_value, input, WIDTH bits: the value applied on load.
REQ-009 The block SHALL have port enable, input, 1 bit: count enable.
REQ-010 The block SHALL have port up_down, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-011 The block SHALL have port sticky_clr, input, 1 bit: clears both sticky flags.
REQ-012 The block SHALL have port count, output, WIDTH bits: the registered count value.
REQ-013 The block SHALL have port overflow, output, 1 bit: a registered single-cycle pulse on an up-boundary event.
REQ-014 The block SHALL have port underflow, output, 1 bit: a registered single-cycle pulse on a down-boundary event.
REQ-015 The block SHALL have port ovf_sticky, output, 1 bit: a latched overflow flag.
REQ-016 The block SHALL have port unf_sticky, output, 1 bit: a latched underflow flag.
REQ-017 The block SHALL have port at_max, output, 1 bit: combinational flag, high when count == MAX_VALUE.
REQ-018 The block SHALL have port at_zero, output, 1 bit: combinational flag, high when count == 0.

Function
REQ-019 Per cycle, the block SHALL apply the command priority clear > load > enable; when none of these is asserted, count SHALL hold.
REQ-020 Clear SHALL set count to 0 on the next edge; overflow and underflow SHALL be 0 that cycle.
REQ-021 Load SHALL set count to min(load_value, MAX_VALUE) on the next edge; overflow and underflow SHALL be 0 that cycle.
REQ-022 On an enabled up-count with count < MAX_VALUE, count SHALL become count+1; on a down-count with count > 0, count SHALL become count-1.
REQ-023 In wrap mode, an up-count at MAX_VALUE SHALL set count to 0 and assert overflow for exactly one cycle.
REQ-024 In wrap mode, a down-count at 0 SHALL set count to MAX_VALUE and assert underflow for exactly one cycle.
REQ-025 In saturate mode, an up-count at MAX_VALUE SHALL hold count and pulse overflow; a down-count at 0 SHALL hold count and pulse underflow.
REQ-026 In every cycle without a boundary event (including enable=0), overflow and underflow SHALL be 0.
REQ-027 overflow and underflow SHALL never be asserted in the same cycle.
REQ-028 Latency SHALL be one cycle: the count and pulse outputs reflect the inputs sampled at the preceding rising edge.
REQ-029 ovf_sticky SHALL set on any overflow event and hold until sticky_clr.
REQ-030 unf_sticky SHALL set on any underflow event and hold until sticky_clr.
REQ-031 When an event and sticky_clr occur in the same cycle, the sticky flag SHALL end up set (the set wins).
REQ-032 Arithmetic SHALL be computed modulo MAX_VALUE+1 without intermediate width overflow; when MAX_VALUE = 2**WIDTH-1, natural wrap SHALL apply.

Reset
REQ-033 Asserting rst_n low SHALL immediately, without waiting for clk, force count=0, overflow=0, underflow=0, ovf_sticky=0 and unf_sticky=0.
REQ-034 Reset asserted mid-count SHALL abort the count, with no event pulse emitted.
REQ-035 The first count SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-036 The shared package counter_pkg SHALL hold the mode constants CNT_MODE_WRAP=0 and CNT_MODE_SAT=1, used for the SATURATE parameter.
REQ-037 The block SHALL be a single flat module with no sub-module; the next-count logic SHALL be one combinational block feeding one registered always block.

Verification
REQ-038 Wrap mode, WIDTH=8, MAX_VALUE=255: load 254, enable up 3 cycles -> count 255, 0, 1; overflow=1 only in the cycle count=0; ovf_sticky=1 afterwards.
REQ-039 Wrap mode, MAX_VALUE=9: count=0, enable down 1 cycle -> count=9, underflow pulse for 1 cycle; up from 9 -> count 0, overflow pulse.
REQ-040 Saturate mode, MAX_VALUE=9: load 9, enable up 4 cycles -> count stays 9, overflow pulses every cycle; down at 0 -> count stays 0, underflow pulses.
REQ-041 Priority: clear=1, load=1 with load_value=5, enable=1 in the same cycle -> count=0; next cycle load=1, enable=1 -> count=5; load_value=200 with MAX_VALUE=9 -> count=9.
REQ-042 Sticky flags: an overflow event coincident with sticky_clr -> ovf_sticky=1; sticky_clr alone next cycle -> ovf_sticky=0.
REQ-043 Reset: rst_n pulled low between clock edges while count=7 -> count=0 and all flags 0 immediately; no pulse after release.

Source files
------------

// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared constants for the parameterised up/down counter.
//               The mode constants select the SATURATE parameter value.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // Boundary behaviour: wrap around modulo MAX_VALUE+1
  localparam int unsigned CNT_MODE_WRAP = 0;
  // Boundary behaviour: hold at the boundary value
  localparam int unsigned CNT_MODE_SAT  = 1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/counter_updown_param.sv
`default_nettype none
// ============================================================================
// Module      : counter_updown_param
// Description : Parameterised up/down counter with terminal count MAX_VALUE,
//               wrap or saturate boundary mode, single-cycle overflow /
//               underflow pulses, sticky event flags and combinational
//               at_max / at_zero status.
//               Command priority each cycle: clear > load > enable.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_updown_param
  import counter_pkg::*;
#(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      MAX_VALUE = '1,
  parameter int unsigned           SATURATE  = CNT_MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up_down,
  input  logic             sticky_clr,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             underflow,
  output logic             ovf_sticky,
  output logic             unf_sticky,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_ZERO = '0;
  localparam logic             c_SAT  = (SATURATE == CNT_MODE_SAT);

  logic [WIDTH-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_ovf_sticky;
  logic             r_unf_sticky;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;
  logic             w_ovf_sticky_nxt;
  logic             w_unf_sticky_nxt;

  // Next-count, event pulses and sticky flags from the prioritised command.
  // The count never exceeds MAX_VALUE (load clamps), so the boundary tests
  // only need >= / == against the terminal values and no wider arithmetic.
  always_comb begin
    w_count_nxt = r_count;
    w_ovf_nxt   = 1'b0;
    w_unf_nxt   = 1'b0;
    if (clear) begin
      w_count_nxt = c_ZERO;
    end else if (load) begin
      w_count_nxt = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
    end else if (enable) begin
      if (up_down) begin
        if (r_count >= MAX_VALUE) begin
          w_ovf_nxt   = 1'b1;
          w_count_nxt = c_SAT ? MAX_VALUE : c_ZERO;
        end else begin
          w_count_nxt = r_count + c_ONE;
        end
      end else begin
        if (r_count == c_ZERO) begin
          w_unf_nxt   = 1'b1;
          w_count_nxt = c_SAT ? c_ZERO : MAX_VALUE;
        end else begin
          w_count_nxt = r_count - c_ONE;
        end
      end
    end
    // A new event wins over a coincident sticky clear
    w_ovf_sticky_nxt = w_ovf_nxt | (r_ovf_sticky & ~sticky_clr);
    w_unf_sticky_nxt = w_unf_nxt | (r_unf_sticky & ~sticky_clr);
  end

  // Counter state, pulses and sticky flags; async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= c_ZERO;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_unf_sticky <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_overflow   <= w_ovf_nxt;
      r_underflow  <= w_unf_nxt;
      r_ovf_sticky <= w_ovf_sticky_nxt;
      r_unf_sticky <= w_unf_sticky_nxt;
    end
  end

  assign count      = r_count;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;
  assign ovf_sticky = r_ovf_sticky;
  assign unf_sticky = r_unf_sticky;
  assign at_max     = (r_count == MAX_VALUE);
  assign at_zero    = (r_count == c_ZERO);

endmodule : counter_updown_param
`default_nettype wire

// File: tb/tb_counter_updown_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_updown_param
// Description : Self-checking bench. Three counter instances share stimulus:
//               wrap/MAX=255, wrap/MAX=9, saturate/MAX=9. A behavioural model
//               using integer arithmetic predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_updown_param;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic       enable = 1'b0;
  logic       up_down = 1'b0;
  logic       sticky_clr = 1'b0;

  logic [7:0] cnt  [NI];
  logic       ovf  [NI];
  logic       unf  [NI];
  logic       os   [NI];
  logic       us   [NI];
  logic       amax [NI];
  logic       azero[NI];

  // Model configuration and state
  int m_max [NI] = '{255, 9, 9};
  bit m_sat [NI] = '{1'b0, 1'b0, 1'b1};
  int m_cnt [NI] = '{0, 0, 0};
  bit m_ovf [NI] = '{1'b0, 1'b0, 1'b0};
  bit m_unf [NI] = '{1'b0, 1'b0, 1'b0};
  bit m_os  [NI] = '{1'b0, 1'b0, 1'b0};
  bit m_us  [NI] = '{1'b0, 1'b0, 1'b0};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_updown_param #(.WIDTH(8)) u_dut_w255 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .sticky_clr(sticky_clr),
    .count(cnt[0]), .overflow(ovf[0]), .underflow(unf[0]), .ovf_sticky(os[0]),
    .unf_sticky(us[0]), .at_max(amax[0]), .at_zero(azero[0]));

  counter_updown_param #(.WIDTH(8), .MAX_VALUE(8'd9), .SATURATE(0)) u_dut_w9 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .sticky_clr(sticky_clr),
    .count(cnt[1]), .overflow(ovf[1]), .underflow(unf[1]), .ovf_sticky(os[1]),
    .unf_sticky(us[1]), .at_max(amax[1]), .at_zero(azero[1]));

  counter_updown_param #(.WIDTH(8), .MAX_VALUE(8'd9), .SATURATE(1)) u_dut_s9 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_value(load_value),
    .enable(enable), .up_down(up_down), .sticky_clr(sticky_clr),
    .count(cnt[2]), .overflow(ovf[2]), .underflow(unf[2]), .ovf_sticky(os[2]),
    .unf_sticky(us[2]), .at_max(amax[2]), .at_zero(azero[2]));

  // Behavioural reference: counting modulo max+1, or clamped in saturate mode
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_os[i] = 0; m_us[i] = 0;
      end else begin
        int n;
        bit o, u;
        n = m_cnt[i]; o = 0; u = 0;
        if (clear) n = 0;
        else if (load) n = (int'(load_value) > m_max[i]) ? m_max[i] : int'(load_value);
        else if (enable && up_down) begin
          n = m_cnt[i] + 1;
          if (n > m_max[i]) begin
            o = 1;
            n = m_sat[i] ? m_max[i] : n % (m_max[i] + 1);
          end
        end else if (enable) begin
          n = m_cnt[i] - 1;
          if (n < 0) begin
            u = 1;
            n = m_sat[i] ? 0 : n + m_max[i] + 1;
          end
        end
        m_cnt[i] = n;
        m_ovf[i] = o;
        m_unf[i] = u;
        m_os[i]  = o | (m_os[i] & !sticky_clr);
        m_us[i]  = u | (m_us[i] & !sticky_clr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("count[%0d]", i), 32'(cnt[i]), 32'(m_cnt[i]));
      check($sformatf("overflow[%0d]", i), 32'(ovf[i]), 32'(m_ovf[i]));
      check($sformatf("underflow[%0d]", i), 32'(unf[i]), 32'(m_unf[i]));
      check($sformatf("ovf_sticky[%0d]", i), 32'(os[i]), 32'(m_os[i]));
      check($sformatf("unf_sticky[%0d]", i), 32'(us[i]), 32'(m_us[i]));
      check($sformatf("at_max[%0d]", i), 32'(amax[i]), 32'(m_cnt[i] == m_max[i]));
      check($sformatf("at_zero[%0d]", i), 32'(azero[i]), 32'(m_cnt[i] == 0));
      check($sformatf("ovf_and_unf[%0d]", i), 32'(ovf[i] & unf[i]), 32'd0);
    end
  endtask

  // Apply one command at the falling edge, let the rising edge take it,
  // then compare at the next falling edge.
  task automatic cyc(input bit c, input bit l, input logic [7:0] lv,
                     input bit e, input bit ud, input bit sc);
    clear = c; load = l; load_value = lv; enable = e; up_down = ud; sticky_clr = sc;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // First count on the first edge after release
    cyc(0, 0, 0, 1, 1, 0);
    check("first_count", 32'(cnt[0]), 32'd1);

    // Wrap MAX=255: 254 -> 255, 0 (overflow), 1
    cyc(0, 1, 8'd254, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    check("w255_255", 32'(cnt[0]), 32'd255);
    cyc(0, 0, 0, 1, 1, 0);
    check("w255_wrap", 32'(cnt[0]), 32'd0);
    check("w255_ovf", 32'(ovf[0]), 32'd1);
    cyc(0, 0, 0, 1, 1, 0);
    check("w255_one", 32'(cnt[0]), 32'd1);
    check("w255_ovf_gone", 32'(ovf[0]), 32'd0);
    check("w255_sticky", 32'(os[0]), 32'd1);

    // Wrap MAX=9: down from 0 -> 9 with underflow, up from 9 -> 0 with overflow
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    check("w9_down_wrap", 32'(cnt[1]), 32'd9);
    check("w9_unf", 32'(unf[1]), 32'd1);
    check("s9_down_hold", 32'(cnt[2]), 32'd0);
    check("s9_unf", 32'(unf[2]), 32'd1);
    cyc(0, 0, 0, 1, 1, 0);
    check("w9_up_wrap", 32'(cnt[1]), 32'd0);
    check("w9_ovf", 32'(ovf[1]), 32'd1);

    // Saturate MAX=9: load 9, up 4 cycles holds with overflow each cycle
    cyc(0, 1, 8'd9, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 1, 1, 0);
      check("s9_hold", 32'(cnt[2]), 32'd9);
      check("s9_ovf", 32'(ovf[2]), 32'd1);
    end

    // Priority and load clamping
    cyc(1, 1, 8'd5, 1, 1, 0);
    check("prio_clear", 32'(cnt[1]), 32'd0);
    cyc(0, 1, 8'd5, 1, 1, 0);
    check("prio_load", 32'(cnt[1]), 32'd5);
    cyc(0, 1, 8'd200, 0, 0, 0);
    check("load_clamp", 32'(cnt[1]), 32'd9);
    check("load_noclamp", 32'(cnt[0]), 32'd200);

    // Sticky: event coincident with clear wins, clear alone then clears
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1, 1);
    check("sticky_set_wins", 32'(os[1]), 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    check("sticky_cleared", 32'(os[1]), 32'd0);

    // Asynchronous reset between edges while count=7
    cyc(0, 1, 8'd7, 0, 0, 0);
    clear = 0; load = 0; enable = 1; up_down = 1; sticky_clr = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(cnt[1]), 32'd0);
    check("async_rst_ovfs", 32'(os[2]), 32'd0);
    compare_all();
    @(negedge clk);
    enable = 0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    compare_all();
    check("no_pulse_after_rst", 32'(ovf[2] | unf[2]), 32'd0);

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 10), 8'($urandom),
          ($urandom_range(0, 99) < 75), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 99) < 10));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_counter_updown_param
`default_nettype wire
